dcache_controller: RTL
======================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter: NUM_LINES, 16, number of direct-mapped lines (power of two, 2..256); line = 4 words (128 bits).
REQ-002 Port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_i  in  1  reset, asynchronous, active-low.
REQ-004 Port: cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
REQ-005 Port: cpu_we_i  in  1  1 = store, 0 = load.
REQ-006 Port: cpu_addr_i  in  32  byte address, word-aligned; offset [3:2], index [3+log2(NUM_LINES):4], tag = remaining upper bits.
REQ-007 Port: cpu_data_i  in  32  store data.
REQ-008 Port: cpu_data_o  out  32  load data.
REQ-009 Port: cpu_stall_o  out  1  freeze PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
REQ-010 Port: mem_req_o  out  1  backing-memory request.
REQ-011 Port: mem_we_o  out  1  1 = line write-back, 0 = line fetch.
REQ-012 Port: mem_addr_o  out  32  line-aligned address (bits [3:0] = 0).
REQ-013 Port: mem_data_o  out  128  write-back line.
REQ-014 Port: mem_data_i  in  128  fetched line.
REQ-015 Port: mem_ack_i  in  1  one-cycle completion pulse from memory.

Function
REQ-016 Write-back, write-allocate cache; per line: valid, dirty, tag, 128-bit data.
REQ-017 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-018 Hit = cpu_req_i & valid[index] & tag match, evaluated only in IDLE.
REQ-019 IDLE hit load: cpu_data_o = addressed word combinationally, same cycle; cpu_stall_o = 0; zero-cycle latency.
REQ-020 IDLE hit store: addressed word written with cpu_data_i and dirty set at the next rising edge; cpu_stall_o = 0.
REQ-021 cpu_data_o = 0 whenever no IDLE load hit.
REQ-022 IDLE miss: cpu_stall_o = 1 combinationally; next state WRITEBACK if victim valid & dirty, else ALLOCATE.
REQ-023 WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 4'b0}, mem_data_o = victim line; on mem_ack_i, clear dirty and go to ALLOCATE.
REQ-024 ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {request tag, index, 4'b0}; on mem_ack_i, load mem_data_i into the line, set valid, clear dirty, write tag, go to IDLE.
REQ-025 Returning to IDLE re-evaluates the held request as a hit; the store merge or load return occurs in that cycle.
REQ-026 cpu_stall_o = 1 in WRITEBACK and ALLOCATE regardless of mem_ack_i.
REQ-027 CPU holds all cpu_* inputs stable while cpu_stall_o = 1; the controller does not latch them.
REQ-028 Without an ack, the controller holds mem_req_o and all mem_* outputs constant indefinitely.
REQ-029 mem_ack_i is ignored while mem_req_o = 0.
REQ-030 In IDLE, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_data_o = 0.
REQ-031 cpu_req_i = 0 in IDLE: no state change, cpu_stall_o = 0.

Reset
REQ-032 rst_i low: state forced to IDLE, all valid and dirty bits cleared, all outputs 0, asynchronously and without a clock edge.
REQ-033 Reset mid-WRITEBACK or mid-ALLOCATE: transaction abandoned, mem_req_o drops immediately; a late mem_ack_i is ignored.
REQ-034 Tag and data arrays need no reset; they are unobservable while valid = 0.

Configuration
REQ-035 Macro DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], both reset to 0.
REQ-036 hit_cnt_o increments once per IDLE hit that was not preceded by a refill for the same request.
REQ-037 miss_cnt_o increments once per IDLE miss; both counters wrap modulo 2^32.
REQ-038 Macro DCACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Verification
REQ-039 After reset, load 0x00 -> stall; ALLOCATE with mem_addr_o = 0x00; ack with line {..,5} -> next cycle cpu_data_o = 5, stall 0.
REQ-040 Store 0x04 = 7 (line resident), then load 0x04 -> no stall on either access; cpu_data_o = 7; dirty[0] = 1.
REQ-041 With NUM_LINES = 16 and dirty line 0, load 0x100 -> WRITEBACK to 0x00 with word1 = 7, then ALLOCATE at 0x100; each state lasts until its ack.
REQ-042 Miss with mem_ack_i delayed 10 cycles -> stall and mem_* outputs held constant for all 10 cycles.
REQ-043 rst_i low during ALLOCATE -> mem_req_o = 0 at once; later load 0x00 misses (valid cleared).
REQ-044 DCACHE_STATS_EN defined: sequence from REQ-039/040 -> miss_cnt_o = 1, hit_cnt_o = 2.

Source files
------------

// File: rtl/dcache_controller.sv
// -----------------------------------------------------------------------------
// dcache_controller
//
// Direct-mapped, write-back / write-allocate data cache sitting in the MEM
// stage of a pipelined CPU. Each line holds 4 words (128 bits), plus valid,
// dirty and tag state. A hit is serviced in zero cycles. A miss stalls the
// pipeline while a dirty victim is written back (WRITEBACK) and then the
// requested line is fetched (ALLOCATE). The held request then completes as a
// hit on the cycle the controller returns to IDLE.
//
// Parameters:
//   NUM_LINES     number of lines (power of two, 2..256)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous, active-low reset
//   cpu_req_i     access valid           cpu_we_i    1 = store, 0 = load
//   cpu_addr_i    word-aligned address   cpu_data_i  store data
//   cpu_data_o    load data (0 unless an IDLE load hit)
//   cpu_stall_o   freezes the pipeline while a miss is serviced
//   mem_req_o     memory request         mem_we_o    1 = write-back, 0 = fetch
//   mem_addr_o    line-aligned address   mem_data_o  write-back line
//   mem_data_i    fetched line           mem_ack_i   one-cycle completion pulse
//   hit_cnt_o / miss_cnt_o   (only with DCACHE_STATS_EN) access statistics
//
// Build option: define DCACHE_STATS_EN to add the hit/miss counters.
// -----------------------------------------------------------------------------
module dcache_controller #(
    parameter int NUM_LINES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_data_o,
    input  logic [127:0] mem_data_i,
    input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    // Address decomposition of the (held) CPU request.
    logic [1:0]       req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_addr_bits;

    assign req_off          = cpu_addr_i[3:2];
    assign req_idx          = cpu_addr_i[4 +: IDX_W];
    assign req_tag          = cpu_addr_i[31 -: TAG_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    logic hit;
    logic store_hit;
    logic wb_done;
    logic alloc_done;

    assign hit        = (state_q == S_IDLE) && cpu_req_i && valid_q[req_idx]
                        && (tag_q[req_idx] == req_tag);
    assign store_hit  = hit && cpu_we_i;
    assign wb_done    = (state_q == S_WRITEBACK) && mem_ack_i;
    assign alloc_done = (state_q == S_ALLOCATE) && mem_ack_i;

    // Next state and all outputs.
    always_comb begin
        state_d     = state_q;
        cpu_data_o  = '0;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (!cpu_we_i) begin
                            cpu_data_o = data_q[req_idx][{req_off, 5'b0} +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = (valid_q[req_idx] && dirty_q[req_idx])
                                      ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[req_idx], req_idx, 4'b0};
                mem_data_o  = data_q[req_idx];
                if (mem_ack_i) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_tag, req_idx, 4'b0};
                if (mem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reset holds every output low without waiting for a clock edge.
        if (!rst_i) begin
            state_d     = S_IDLE;
            cpu_data_o  = '0;
            cpu_stall_o = 1'b0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_data_o  = '0;
        end
    end

    // Control state: FSM, valid and dirty bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (alloc_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end else if (wb_done) begin
                dirty_q[req_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; they are hidden behind valid.
    always_ff @(posedge clk_i) begin
        if (alloc_done) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_data_i;
        end else if (store_hit) begin
            data_q[req_idx][{req_off, 5'b0} +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    // refill_q marks the IDLE cycle right after a refill, where the held
    // request hits again; that re-evaluation is not a new hit.
    logic        refill_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (alloc_done) begin
                refill_q <= 1'b1;
            end else if (state_q == S_IDLE) begin
                refill_q <= 1'b0;
            end
            if (hit && !refill_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == S_IDLE) && cpu_req_i && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
